// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and counter sizing.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // funct3 encodings of the M extension
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // FSM states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // iteration counter width; one spare bit so XLEN itself is representable
  function automatic int cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One shift-add (multiply) or
// restoring-subtract (divide) step per cycle on unsigned magnitudes;
// signs are stripped in PREP and reapplied in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = cnt_w(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state;
  logic [2:0]        f3_r;
  logic [XLEN-1:0]   a_r;      // raw op_a until PREP, then |op_a|
  logic [XLEN-1:0]   b_r;      // raw op_b until PREP, then |op_b|
  logic              sa_r, sb_r;
  logic [2*XLEN-1:0] acc;      // mul: {hi, multiplier/lo}; div: {rem, dividend/quot}
  logic [CW-1:0]     cnt;

  logic              is_div, sgn_a_op, sgn_b_op, neg_a, neg_b, div0, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo, rem, quo_s, rem_s, fix_res;

  // which operands are treated as signed for each op
  always_comb begin
    sgn_a_op = 1'b0;
    sgn_b_op = 1'b0;
    case (f3_r)
      F3_MUL:    begin sgn_a_op = 1'b0; sgn_b_op = 1'b0; end
      F3_MULH:   begin sgn_a_op = 1'b1; sgn_b_op = 1'b1; end
      F3_MULHSU: begin sgn_a_op = 1'b1; sgn_b_op = 1'b0; end
      F3_MULHU:  begin sgn_a_op = 1'b0; sgn_b_op = 1'b0; end
      F3_DIV:    begin sgn_a_op = 1'b1; sgn_b_op = 1'b1; end
      F3_DIVU:   begin sgn_a_op = 1'b0; sgn_b_op = 1'b0; end
      F3_REM:    begin sgn_a_op = 1'b1; sgn_b_op = 1'b1; end
      F3_REMU:   begin sgn_a_op = 1'b0; sgn_b_op = 1'b0; end
      default:   begin sgn_a_op = 1'b0; sgn_b_op = 1'b0; end
    endcase
  end

  // PREP: magnitudes, special-case detection and their fixed results
  always_comb begin
    is_div   = f3_r[2];
    neg_a    = sgn_a_op & a_r[XLEN-1];
    neg_b    = sgn_b_op & b_r[XLEN-1];
    mag_a    = neg_a ? -a_r : a_r;
    mag_b    = neg_b ? -b_r : b_r;
    div0     = is_div && (b_r == '0);
    ovf      = is_div && !f3_r[0] && (a_r == MOST_NEG) && (b_r == '1);
    // REM/REMU: a on div0, 0 on overflow; DIV/DIVU: all ones on div0, a (=MOST_NEG) on overflow
    if (f3_r[1]) spec_res = div0 ? a_r : '0;
    else         spec_res = div0 ? '1 : a_r;
  end

  // CALC: one multiply or divide step
  always_comb begin
    // shift-add: add multiplicand into the high half when the current multiplier bit is set
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_r} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // restoring divide: bring in next dividend bit, subtract if it fits
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = rem_sh - {1'b0, b_r};
    if (diff[XLEN]) div_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else            div_next = {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
  end

  // FIX: reapply signs and pick the architectural result
  always_comb begin
    prod  = (sa_r ^ sb_r) ? -acc : acc;
    quo   = acc[XLEN-1:0];
    rem   = acc[2*XLEN-1:XLEN];
    quo_s = (sa_r ^ sb_r) ? -quo : quo;
    rem_s = sa_r ? -rem : rem;
    if (is_div)              fix_res = f3_r[1] ? rem_s : quo_s;
    else if (f3_r == F3_MUL) fix_res = prod[XLEN-1:0];
    else                     fix_res = prod[2*XLEN-1:XLEN];
  end

  // control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      f3_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_r   <= op_a;
          b_r   <= op_b;
          f3_r  <= funct3;
          state <= S_PREP;
        end
        S_PREP: begin
          sa_r <= neg_a;
          sb_r <= neg_b;
          a_r  <= mag_a;
          b_r  <= mag_b;
          cnt  <= '0;
          if (div0 || ovf) begin
            result <= spec_res;
            state  <= S_DONE;
          end else begin
            acc   <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake
// corner cases, async reset abort and randomized ops against a 64-bit
// arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // architectural result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    longint q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    q  = 0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; q = $signed(sa) / $signed(sb); return q[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; q = $signed(sa) % $signed(sb); return q[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Call at a negedge with the unit idle. poke>0: spurious start in that
  // cycle; poke<0: start raised in the done cycle. Returns at negedge of
  // the cycle after done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int poke);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (busy !== 1'b1) busy_ok = 0;
      if (k == poke) begin start = 1'b1; op_a = $urandom; op_b = $urandom; end
      else start = 1'b0;
    end
    check({tag, "_lat"}, lat, ref_latency(f, a, b));
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    if (poke < 0) begin start = 1'b1; op_a = $urandom; op_b = $urandom; end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed arithmetic
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        0);
    run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         0);

    // special cases (done in cycle 2)
    run_op("divu0",  3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 0);
    run_op("rem0",   3'd6, 32'h1234,      32'd0,         32'h1234,      0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

    // handshake: spurious start mid-op, start during done, back-to-back
    run_op("poke10", 3'd4, 32'd1000,      32'd3,         32'd333,       10);
    run_op("pokedn", 3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, -1);
    run_op("b2b_1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("b2b_2",  3'd5, 32'd100,       32'd7,         32'd14,        0);

    // async reset during a MUL aborts it
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("arst_nodone", {31'b0, saw_done}, 32'd0);
    run_op("after_rst", 3'd0, 32'd5, 32'd9, 32'd45, 0);

    // randomized ops, biased toward boundary operands
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = $urandom_range(0, 15);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, ref_model(rf, ra, rb), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file and beside the ALU.
- Consumes the two source-operand read values plus funct3.
- Holds the core via busy while it computes.
- Presents a 32-bit result for register-file writeback in the single cycle that done is high.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  XLEN  rs1 operand (dividend / multiplicand).
op_b  input  XLEN  rs2 operand (divisor / multiplier).
busy  output  1  high in PREP, CALC and FIX; core stalls PC and writeback while high.
done  output  1  one-cycle pulse; result valid, core writes rd this cycle.
result  output  XLEN  registered result; holds last value until next completion.

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, all internal regs 0. Reset mid-operation aborts the op; no done pulse follows.
- States:
  - IDLE: start=1 latches op_a, op_b, funct3 -> PREP.
  - PREP: compute sign flags and magnitudes.
    - Signed ops (MULH a and b, MULHSU a only, DIV/REM both): magnitude = two's-complement abs.
    - Div by zero (op_b=0) or signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): load special result -> DONE.
    - Otherwise clear accumulator and iteration counter -> CALC.
  - CALC: one iteration per cycle, exactly XLEN cycles; counter 0..XLEN-1, then -> FIX.
    - Multiply: shift-add on unsigned magnitudes into a 2*XLEN product.
    - Divide: restoring; shift remainder left with next dividend bit, subtract divisor if no borrow, shift quotient bit in.
  - FIX: apply sign correction and select the output.
    - Multiply: negate the 2*XLEN product if sign_a XOR sign_b (sign_b forced 0 for MULHSU/MULHU). MUL takes low XLEN bits; the MULH family takes high XLEN bits.
    - Divide: quotient negated if sign_a XOR sign_b; remainder negated if sign_a.
    - Write result, then -> DONE.
  - DONE: done=1, busy=0 -> IDLE unconditionally.
- Start outside IDLE is ignored, including in DONE. The earliest next start is the cycle after done.
- Latency, with start sampled at the end of cycle 0:
  - Normal ops: PREP in cycle 1, CALC in cycles 2..XLEN+1, FIX in cycle XLEN+2, done in cycle XLEN+3 (cycle 35 for XLEN=32).
  - Special cases: done in cycle 2.
- Special results (per RISC-V spec):
  - DIV/DIVU by 0: quotient = all ones.
  - REM/REMU by 0: remainder = op_a.
  - Signed overflow: DIV gives 0x80000000, REM gives 0.
- Operands are latched at start; input changes after start have no effect.
- All arithmetic is modulo 2^XLEN or 2^(2*XLEN); no exceptions are raised.

Decomposition:
- Package muldiv_pkg: funct3 op constants, state encoding (IDLE, PREP, CALC, FIX, DONE), counter width clog2(XLEN)+1.
- Single module. The control FSM and datapath are small enough that no sub-module is warranted.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> done in cycle 35, result 0xFFFFFFEB, busy high in cycles 1-34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with done in cycle 2:
  - DIVU 0x1234 / 0 -> 0xFFFFFFFF.
  - REM 0x1234 / 0 -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Handshake:
  - start pulsed in cycle 10 of a running DIV -> ignored, single done at cycle 35.
  - Back-to-back ops with start in cycle 36 -> second done in cycle 71.
  - Changing op_a after start -> no effect on result.
- Async rst asserted in cycle 20 of a MUL -> busy, done and result go to 0 immediately; no done pulse afterwards; the next start works normally.
